y86_fetch_seq: RTL
==================

// Module: y86_fetch_seq
// PURPOSE
//  Multi-cycle Y86-64 fetch/decode front end. Reads instruction bytes from a byte-wide
//  instruction memory through a req/rvalid handshake and assembles icode, ifun, rA, rB,
//  valC and valP. Presents each decoded instruction to the execute stage over a
//  valid/ready handshake, and takes a PC redirect (jXX/call/ret) back at hand-off.
// PARAMETERS
//  RESET_PC  64'd0  PC loaded on reset; address of the first fetched byte
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  imem_req     out  1   byte read request; held until imem_rvalid
//  imem_addr    out  64  byte address; stable while imem_req=1
//  imem_rdata   in   8   read byte; valid when imem_rvalid=1
//  imem_rvalid  in   1   response strobe; ignored unless imem_req=1
//  out_valid    out  1   decoded instruction available
//  out_ready    in   1   execute stage accepts the instruction
//  icode        out  4   instruction code (byte0[7:4])
//  ifun         out  4   function code (byte0[3:0])
//  rA           out  4   register A (byte1[7:4]); 4'hF when no register byte
//  rB           out  4   register B (byte1[3:0]); 4'hF when no register byte
//  valC         out  64  constant, little-endian; 0 when absent
//  valP         out  64  pc + instruction length, modulo 2^64
//  pc_load      in   1   redirect; sampled only on the accept cycle
//  pc_next      in   64  redirect target
//  halted       out  1   halt instruction accepted; fetch stopped
//  instr_err    out  1   invalid icode/ifun decoded; fetch stopped
// BEHAVIOUR
//  Reset: async. PC=RESET_PC; state=S_OP; all outputs 0 except rA=rB=4'hF. imem_req
//   goes low asynchronously. Memory is reset by the same rst_n; no stale rvalid exists.
//  Lengths: 0 halt, 1 nop, 9 ret = 1 byte; 2 cmov, 6 OPq, A push, B pop = 2 bytes;
//   7 jXX, 8 call = 9 bytes (no reg byte); 3 irmov, 4 rmmov, 5 mrmov = 10 bytes.
//  Legal ifun: 0-6 for icode 2 and 7; 0-3 for icode 6; 0 for all others.
//  FSM states:
//   S_OP    req addr=PC; on rvalid latch icode/ifun. Illegal icode (>B) or ifun -> S_ERR.
//           1-byte instruction -> S_OUT; reg byte next -> S_REG; else -> S_CONST.
//   S_REG   req addr=PC+1; on rvalid latch rA/rB; icode 3/4/5 -> S_CONST, else -> S_OUT.
//   S_CONST 3-bit byte counter k=0..7; addr=PC+off+k (off=2 with reg byte, else 1);
//           byte k -> valC[8k+7:8k]; after k=7 -> S_OUT.
//   S_OUT   out_valid=1; all fields held stable until out_ready. Accept (valid&ready):
//           PC <= pc_load ? pc_next : valP; icode 0 -> S_HALT, else -> S_OP.
//   S_HALT  halted=1, imem_req=0; exit only by reset.
//   S_ERR   instr_err=1, imem_req=0, out_valid=0; exit only by reset.
//  imem_req deasserts in the cycle after each rvalid and re-asserts for the next byte,
//   so each byte costs at least 2 cycles; memory latency is unbounded.
//  out_valid is registered; no combinational path from out_ready to out_valid.
//  At least one cycle with imem_req=0 separates the accept from the next opcode request.
//  Address arithmetic (PC+offset, valP) wraps modulo 2^64.
//  pc_load outside an accept cycle has no effect.
//  Fields not supplied by the current instruction are driven to defaults
//   (rA=rB=F, valC=0), never to values left over from the previous instruction.
// TESTING
//  1) Mem @0: 30 F2 0A 00 00 00 00 00 00 00, ready=1 -> icode=3 ifun=0 rA=F rB=2 valC=10 valP=10
//  2) @0: 60 23, out_ready low 5 cycles -> out_valid and fields stay stable; after accept next req addr=2
//  3) @0: 70 20 00 00 00 00 00 00 00; accept with pc_load=1 pc_next=0x20 -> next req addr=0x20, valP=9
//  4) @0: 10 00 -> nop (valP=1) then halt accepted -> halted=1, imem_req stays 0 for 100 cycles
//  5) @0: C0 / separately 65 -> instr_err=1, out_valid never asserts
//  6) rvalid latency 0-7 random cycles; rst_n low mid S_CONST -> req drops immediately, restart at RESET_PC

Source files
------------

// File: rtl/y86_fetch_seq.sv
// y86_fetch_seq: multi-cycle Y86-64 fetch/decode front end.
// Fetches one byte per request from a byte-wide memory. It assembles icode/ifun,
// the optional register byte and the optional 8-byte constant. It then hands the
// decoded instruction to execute over valid/ready.
module y86_fetch_seq #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_rvalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  input  logic        pc_load,
  input  logic [63:0] pc_next,
  output logic        halted,
  output logic        instr_err
);

  typedef enum logic [2:0] {S_OP, S_REG, S_CONST, S_OUT, S_HALT, S_ERR} state_t;

  state_t      state_q;
  logic [63:0] pc_q, addr_q, valc_q, valp_q;
  logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
  logic [2:0]  k_q;
  logic        req_q, ovld_q, halt_q, err_q, reg_q, cst_q;

  // opcode byte decode: legality, length, and which trailing fields follow
  logic [3:0]  op_ic, op_fn, op_len;
  logic        op_legal, op_reg, op_const;
  logic [63:0] pc_d, const_addr_d;

  assign op_ic = imem_rdata[7:4];
  assign op_fn = imem_rdata[3:0];

  // length and ifun legality per icode
  always_comb begin
    op_len   = 4'd1;
    op_legal = 1'b0;
    case (op_ic)
      4'h0, 4'h1, 4'h9: begin op_len = 4'd1;  op_legal = (op_fn == 4'd0); end
      4'h2:             begin op_len = 4'd2;  op_legal = (op_fn <= 4'd6); end
      4'h6:             begin op_len = 4'd2;  op_legal = (op_fn <= 4'd3); end
      4'hA, 4'hB:       begin op_len = 4'd2;  op_legal = (op_fn == 4'd0); end
      4'h7:             begin op_len = 4'd9;  op_legal = (op_fn <= 4'd6); end
      4'h8:             begin op_len = 4'd9;  op_legal = (op_fn == 4'd0); end
      4'h3, 4'h4, 4'h5: begin op_len = 4'd10; op_legal = (op_fn == 4'd0); end
      default:          begin op_len = 4'd1;  op_legal = 1'b0; end
    endcase
  end

  // 2- and 10-byte forms carry a register byte; 9- and 10-byte forms carry valC
  assign op_reg   = (op_len == 4'd2) || (op_len == 4'd10);
  assign op_const = (op_len >= 4'd9);

  assign pc_d         = pc_load ? pc_next : valp_q;
  assign const_addr_d = pc_q + (reg_q ? 64'd2 : 64'd1) + {61'd0, k_q};

  // fetch FSM: each byte is a request phase followed by a latch-on-rvalid phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OP;
      pc_q    <= RESET_PC;
      addr_q  <= 64'd0;
      req_q   <= 1'b0;
      ovld_q  <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      icode_q <= 4'h0;
      ifun_q  <= 4'h0;
      ra_q    <= 4'hF;
      rb_q    <= 4'hF;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      k_q     <= 3'd0;
      reg_q   <= 1'b0;
      cst_q   <= 1'b0;
    end else begin
      case (state_q)
        S_OP: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            addr_q <= pc_q;
          end else if (imem_rvalid) begin
            // a new instruction starts: drop every field from the previous one
            req_q   <= 1'b0;
            icode_q <= op_ic;
            ifun_q  <= op_fn;
            ra_q    <= 4'hF;
            rb_q    <= 4'hF;
            valc_q  <= 64'd0;
            valp_q  <= pc_q + {60'd0, op_len};
            reg_q   <= op_reg;
            cst_q   <= op_const;
            k_q     <= 3'd0;
            if (!op_legal) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else if (op_reg) begin
              state_q <= S_REG;
            end else if (op_const) begin
              state_q <= S_CONST;
            end else begin
              state_q <= S_OUT;
              ovld_q  <= 1'b1;
            end
          end
        end
        S_REG: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            addr_q <= pc_q + 64'd1;
          end else if (imem_rvalid) begin
            req_q <= 1'b0;
            ra_q  <= imem_rdata[7:4];
            rb_q  <= imem_rdata[3:0];
            if (cst_q) begin
              state_q <= S_CONST;
            end else begin
              state_q <= S_OUT;
              ovld_q  <= 1'b1;
            end
          end
        end
        S_CONST: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            addr_q <= const_addr_d;
          end else if (imem_rvalid) begin
            req_q                      <= 1'b0;
            valc_q[{k_q, 3'b000} +: 8] <= imem_rdata;
            k_q                        <= k_q + 3'd1;
            if (k_q == 3'd7) begin
              state_q <= S_OUT;
              ovld_q  <= 1'b1;
            end
          end
        end
        S_OUT: begin
          // redirect is only honoured on the accept edge
          if (out_ready) begin
            ovld_q <= 1'b0;
            pc_q   <= pc_d;
            if (icode_q == 4'h0) begin
              state_q <= S_HALT;
              halt_q  <= 1'b1;
            end else begin
              state_q <= S_OP;
            end
          end
        end
        S_HALT, S_ERR: begin
          req_q <= 1'b0;
        end
        default: state_q <= S_ERR;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign out_valid = ovld_q;
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = ra_q;
  assign rB        = rb_q;
  assign valC      = valc_q;
  assign valP      = valp_q;
  assign halted    = halt_q;
  assign instr_err = err_q;

endmodule
